// File: rtl/deadtime_gen_multi_if.sv
// Bus between the PWM/modulator side and the multi-channel deadtime stage.
// master drives commands and configuration; slave returns gates and status.
interface deadtime_gen_multi_if #(
   parameter int N_CH = 2,
   parameter int DT_W = 8
);
   logic [N_CH-1:0]   sp;
   logic [DT_W-1:0]   dt_cycles;
   logic              en;
   logic              fault;
   logic              fault_clr;
   logic [2*N_CH-1:0] s;
   logic [N_CH-1:0]   dead_active;
   logic              fault_active;

   modport master (
      output sp, dt_cycles, en, fault, fault_clr,
      input  s, dead_active, fault_active
   );

   modport slave (
      input  sp, dt_cycles, en, fault, fault_clr,
      output s, dead_active, fault_active
   );
endinterface

// File: rtl/deadtime_gen_multi.sv
// N_CH complementary gate pairs with programmable deadtime, a minimum-deadtime floor,
// enable and a sticky fault shutdown. Each pair is driven from its own small FSM.
module deadtime_gen_multi #(
   parameter int N_CH   = 2,
   parameter int DT_W   = 8,
   parameter int MIN_DT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   deadtime_gen_multi_if.slave  bus
);
   typedef enum logic [1:0] {ST_OFF, ST_HI, ST_LO, ST_DEAD} state_t;

   localparam logic [DT_W-1:0] MIN_DT_V = DT_W'(MIN_DT);
   localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);

   state_t            r_state     [N_CH];
   state_t            w_state_nxt [N_CH];
   logic [N_CH-1:0]   r_tgt;
   logic [N_CH-1:0]   w_tgt_nxt;
   logic [DT_W-1:0]   r_cnt       [N_CH];
   logic [DT_W-1:0]   w_cnt_nxt   [N_CH];
   logic [DT_W-1:0]   r_dt        [N_CH];
   logic [DT_W-1:0]   w_dt_nxt    [N_CH];
   logic [2*N_CH-1:0] r_s;
   logic [2*N_CH-1:0] w_s_nxt;
   logic [N_CH-1:0]   r_dead;
   logic [N_CH-1:0]   w_dead_nxt;
   logic              r_fault_active;
   logic              w_halt;
   logic [DT_W-1:0]   w_dt_eff;

   // A fault acts on the edge it is sampled, before the latch has captured it.
   assign w_halt   = ~bus.en | bus.fault | r_fault_active;
   assign w_dt_eff = (bus.dt_cycles < MIN_DT_V) ? MIN_DT_V : bus.dt_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_active <= 1'b0;
         r_tgt          <= '0;
         r_s            <= '0;
         r_dead         <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= ST_OFF;
            r_cnt[i]   <= '0;
            r_dt[i]    <= MIN_DT_V;
         end
      end else begin
         if (bus.fault)
            r_fault_active <= 1'b1;
         else if (bus.fault_clr)
            r_fault_active <= 1'b0;
         r_tgt  <= w_tgt_nxt;
         r_s    <= w_s_nxt;
         r_dead <= w_dead_nxt;
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
            r_dt[i]    <= w_dt_nxt[i];
         end
      end
   end

   always_comb begin
      w_tgt_nxt = r_tgt;
      for (int i = 0; i < N_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_dt_nxt[i]    = r_dt[i];
         case (r_state[i])
            ST_OFF: begin
               if (!w_halt) begin
                  w_state_nxt[i] = ST_DEAD;
                  w_tgt_nxt[i]   = bus.sp[i];
                  w_cnt_nxt[i]   = '0;
                  w_dt_nxt[i]    = w_dt_eff;
               end
            end
            ST_HI, ST_LO: begin
               if (w_halt) begin
                  w_state_nxt[i] = ST_OFF;
               end else if (bus.sp[i] != (r_state[i] == ST_HI)) begin
                  w_state_nxt[i] = ST_DEAD;
                  w_tgt_nxt[i]   = bus.sp[i];
                  w_cnt_nxt[i]   = '0;
                  w_dt_nxt[i]    = w_dt_eff;
               end
            end
            ST_DEAD: begin
               // A command change mid-interval restarts the full deadtime, so short glitches never reach the gates.
               if (w_halt) begin
                  w_state_nxt[i] = ST_OFF;
               end else if (bus.sp[i] != r_tgt[i]) begin
                  w_tgt_nxt[i]   = bus.sp[i];
                  w_cnt_nxt[i]   = '0;
                  w_dt_nxt[i]    = w_dt_eff;
               end else if (r_cnt[i] == r_dt[i] - CNT_ONE) begin
                  w_state_nxt[i] = r_tgt[i] ? ST_HI : ST_LO;
               end else begin
                  w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
               end
            end
            default: w_state_nxt[i] = ST_OFF;
         endcase
      end
   end

   // Outputs are decoded from the next state so the registered gates change on the same edge as the state.
   always_comb begin
      w_s_nxt    = '0;
      w_dead_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         case (w_state_nxt[i])
            ST_HI:   w_s_nxt[2*i]     = 1'b1;
            ST_LO:   w_s_nxt[2*i+1]   = 1'b1;
            ST_DEAD: w_dead_nxt[i]    = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.s            = r_s;
   assign bus.dead_active  = r_dead;
   assign bus.fault_active = r_fault_active;
endmodule

// File: tb/tb_deadtime_gen_multi.sv
// Directed and randomized checks of deadtime_gen_multi with two channels.
module tb_deadtime_gen_multi;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [1:0] mprev [2];
   int         mrun  [2];
   int         mreq;

   deadtime_gen_multi_if #(.N_CH(2), .DT_W(8)) dif ();

   deadtime_gen_multi #(.N_CH(2), .DT_W(8), .MIN_DT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dif.sp = 2'b00; dif.dt_cycles = 8'd4; dif.en = 1'b1;
      dif.fault = 1'b0; dif.fault_clr = 1'b0;
      #3;
      total++; if (dif.s !== 4'b0000) begin bad++; $display("FAIL reset_s: got %b want 0000", dif.s); end
      total++; if (dif.dead_active !== 2'b00) begin bad++; $display("FAIL reset_dead: got %b want 00", dif.dead_active); end
      total++; if (dif.fault_active !== 1'b0) begin bad++; $display("FAIL reset_fa: got %b want 0", dif.fault_active); end
      dif.sp = 2'b11;
      tick(); tick();
      total++; if (dif.s !== 4'b0000) begin bad++; $display("FAIL reset_hold_s: got %b want 0000", dif.s); end
      dif.sp = 2'b00;
      #3 rst_n = 1'b1;
   endtask

   task automatic test_basic_dt4();
      dif.dt_cycles = 8'd4; dif.sp = 2'b00;
      repeat (10) tick();
      total++; if (dif.s !== 4'b1010) begin bad++; $display("FAIL basic_lo: got %b want 1010", dif.s); end
      dif.sp = 2'b01;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (dif.s[1:0] !== 2'b00 || dif.dead_active[0] !== 1'b1)
            begin bad++; $display("FAIL basic_rise_dead%0d: got s=%b dead=%b want s=00 dead=1", k, dif.s[1:0], dif.dead_active[0]); end
      end
      tick();
      total++; if (dif.s !== 4'b1001 || dif.dead_active !== 2'b00)
         begin bad++; $display("FAIL basic_hi: got s=%b dead=%b want s=1001 dead=00", dif.s, dif.dead_active); end
      dif.sp = 2'b00;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (dif.s[1:0] !== 2'b00) begin bad++; $display("FAIL basic_fall_dead%0d: got %b want 00", k, dif.s[1:0]); end
      end
      tick();
      total++; if (dif.s !== 4'b1010) begin bad++; $display("FAIL basic_lo2: got %b want 1010", dif.s); end
   endtask

   task automatic test_min_and_max_dt();
      int n;
      dif.dt_cycles = 8'd0;
      dif.sp = 2'b01;
      tick();
      total++; if (dif.s[1:0] !== 2'b00 || dif.dead_active[0] !== 1'b1)
         begin bad++; $display("FAIL mindt_dead_r: got s=%b dead=%b want 00/1", dif.s[1:0], dif.dead_active[0]); end
      tick();
      total++; if (dif.s[1:0] !== 2'b01) begin bad++; $display("FAIL mindt_hi: got %b want 01", dif.s[1:0]); end
      dif.sp = 2'b00;
      tick();
      total++; if (dif.s[1:0] !== 2'b00) begin bad++; $display("FAIL mindt_dead_f: got %b want 00", dif.s[1:0]); end
      tick();
      total++; if (dif.s[1:0] !== 2'b10) begin bad++; $display("FAIL mindt_lo: got %b want 10", dif.s[1:0]); end
      // 255-cycle interval; a dt_cycles change mid-interval must not shorten it
      dif.dt_cycles = 8'd255;
      dif.sp = 2'b01;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (dif.s[1:0] !== 2'b00) break;
         n++;
         if (n == 10) dif.dt_cycles = 8'd4;
      end
      total++; if (n != 255) begin bad++; $display("FAIL maxdt_len: got %0d want 255", n); end
      total++; if (dif.s[1:0] !== 2'b01) begin bad++; $display("FAIL maxdt_hi: got %b want 01", dif.s[1:0]); end
   endtask

   task automatic test_glitch();
      int n;
      logic seen10;
      dif.dt_cycles = 8'd6; dif.sp = 2'b01;
      repeat (12) tick();
      total++; if (dif.s[1:0] !== 2'b01) begin bad++; $display("FAIL glitch_pre: got %b want 01", dif.s[1:0]); end
      seen10 = 1'b0;
      dif.sp = 2'b00;
      tick();
      total++; if (dif.s[1:0] !== 2'b00) begin bad++; $display("FAIL glitch_off: got %b want 00", dif.s[1:0]); end
      tick(); tick();
      if (dif.s[1:0] == 2'b10) seen10 = 1'b1;
      dif.sp = 2'b01;
      tick();
      total++; if (dif.s[1:0] !== 2'b00 || dif.dead_active[0] !== 1'b1)
         begin bad++; $display("FAIL glitch_restart: got s=%b dead=%b want 00/1", dif.s[1:0], dif.dead_active[0]); end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (dif.s[1:0] == 2'b10) seen10 = 1'b1;
         if (dif.s[1:0] !== 2'b00) break;
      end
      total++; if (n != 6 || dif.s[1:0] !== 2'b01)
         begin bad++; $display("FAIL glitch_return: got n=%0d s=%b want n=6 s=01", n, dif.s[1:0]); end
      total++; if (seen10 !== 1'b0) begin bad++; $display("FAIL glitch_no10: got %b want 0", seen10); end
   endtask

   task automatic test_fault();
      int n;
      dif.dt_cycles = 8'd3; dif.sp = 2'b11;
      repeat (10) tick();
      total++; if (dif.s !== 4'b0101) begin bad++; $display("FAIL fault_pre: got %b want 0101", dif.s); end
      dif.fault = 1'b1;
      tick();
      total++; if (dif.s !== 4'b0000 || dif.fault_active !== 1'b1 || dif.dead_active !== 2'b00)
         begin bad++; $display("FAIL fault_trip: got s=%b fa=%b dead=%b want 0000/1/00", dif.s, dif.fault_active, dif.dead_active); end
      dif.fault = 1'b0;
      tick();
      total++; if (dif.s !== 4'b0000 || dif.fault_active !== 1'b1)
         begin bad++; $display("FAIL fault_sticky: got s=%b fa=%b want 0000/1", dif.s, dif.fault_active); end
      dif.fault = 1'b1; dif.fault_clr = 1'b1;
      tick();
      total++; if (dif.fault_active !== 1'b1) begin bad++; $display("FAIL fault_set_wins: got %b want 1", dif.fault_active); end
      dif.fault = 1'b0;
      tick();
      total++; if (dif.fault_active !== 1'b0 || dif.s !== 4'b0000)
         begin bad++; $display("FAIL fault_clear: got fa=%b s=%b want 0/0000", dif.fault_active, dif.s); end
      dif.fault_clr = 1'b0;
      tick();
      total++; if (dif.dead_active !== 2'b11 || dif.s !== 4'b0000)
         begin bad++; $display("FAIL fault_dead: got dead=%b s=%b want 11/0000", dif.dead_active, dif.s); end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (dif.s !== 4'b0000) break;
      end
      total++; if (n != 3 || dif.s !== 4'b0101)
         begin bad++; $display("FAIL fault_resume: got n=%0d s=%b want n=3 s=0101", n, dif.s); end
   endtask

   task automatic test_enable();
      int n;
      dif.en = 1'b0;
      tick();
      total++; if (dif.s !== 4'b0000 || dif.dead_active !== 2'b00)
         begin bad++; $display("FAIL en_off: got s=%b dead=%b want 0000/00", dif.s, dif.dead_active); end
      tick();
      dif.en = 1'b1;
      tick();
      total++; if (dif.dead_active !== 2'b11 || dif.s !== 4'b0000)
         begin bad++; $display("FAIL en_dead: got dead=%b s=%b want 11/0000", dif.dead_active, dif.s); end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (dif.s !== 4'b0000) break;
      end
      total++; if (n != 3 || dif.s !== 4'b0101)
         begin bad++; $display("FAIL en_resume: got n=%0d s=%b want n=3 s=0101", n, dif.s); end
   endtask

   task automatic test_async_reset();
      int n;
      dif.dt_cycles = 8'd5; dif.sp = 2'b01;
      tick(); tick();
      total++; if (dif.s !== 4'b0001 || dif.dead_active !== 2'b10)
         begin bad++; $display("FAIL arst_pre: got s=%b dead=%b want 0001/10", dif.s, dif.dead_active); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (dif.s !== 4'b0000 || dif.dead_active !== 2'b00 || dif.fault_active !== 1'b0)
         begin bad++; $display("FAIL arst_now: got s=%b dead=%b fa=%b want 0000/00/0", dif.s, dif.dead_active, dif.fault_active); end
      #1 rst_n = 1'b1;
      dif.sp = 2'b11;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (dif.s !== 4'b0000) break;
      end
      total++; if (n != 6 || dif.s !== 4'b0101)
         begin bad++; $display("FAIL arst_release: got n=%0d s=%b want n=6 s=0101", n, dif.s); end
   endtask

   task automatic mon();
      logic [1:0] pr;
      for (int c = 0; c < 2; c++) begin
         pr = dif.s[2*c +: 2];
         total++; if (pr === 2'b11) begin bad++; $display("FAIL rand_overlap ch%0d: got 11 want not 11", c); end
         if (pr === 2'b00) begin
            mrun[c]++;
         end else begin
            if (mprev[c] === 2'b00) begin
               total++; if (mrun[c] < mreq)
                  begin bad++; $display("FAIL rand_deadtime ch%0d: got %0d cycles want >=%0d", c, mrun[c], mreq); end
            end else if (pr !== mprev[c]) begin
               total++; bad++; $display("FAIL rand_direct ch%0d: got %b after %b want 00 between", c, pr, mprev[c]);
            end
            mrun[c] = 0;
         end
         mprev[c] = pr;
      end
   endtask

   task automatic test_random();
      int dts [8];
      dts = '{0, 1, 2, 3, 5, 7, 2, 4};
      mprev[0] = dif.s[1:0]; mprev[1] = dif.s[3:2];
      mrun[0] = 0; mrun[1] = 0;
      mreq = 5;
      for (int seg = 0; seg < 8; seg++) begin
         dif.en = 1'b0; dif.fault = 1'b0; dif.fault_clr = 1'b0;
         tick(); mon();
         dif.dt_cycles = 8'(dts[seg]);
         mreq = (dts[seg] < 1) ? 1 : dts[seg];
         tick(); mon();
         for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) dif.sp[0] = ~dif.sp[0];
            if ($urandom_range(0, 5) == 0) dif.sp[1] = ~dif.sp[1];
            dif.en        = ($urandom_range(0, 63) != 0);
            dif.fault     = ($urandom_range(0, 199) == 0);
            dif.fault_clr = ($urandom_range(0, 15) == 0);
            tick(); mon();
         end
      end
      dif.fault = 1'b0; dif.fault_clr = 1'b0; dif.en = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic_dt4();
      test_min_and_max_dt();
      test_glitch();
      test_fault();
      test_enable();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
